reg_cmd_parser: RTL



---
 rtl/reg_cmd_parser.sv | 83 ++++++++
 1 files changed

// File: rtl/reg_cmd_parser.sv
// reg_cmd_parser: byte-stream command parser driving the register wrapper bus.
// Commands: 0x57 addr d3 d2 d1 d0 writes data to addr; 0x52 addr returns rd_data as 4 bytes, MSB first.
// Ports: clk/rst (sync active-high); rx_data/rx_valid/rx_ready command byte input;
//        addr_out/data_out/write_en register bus; rd_data read mux return;
//        tx_data/tx_valid/tx_ready response bytes; err_pulse bad opcode or timeout.
module reg_cmd_parser #(
   parameter int         REG_ADDR_WIDTH = 8,
   parameter int         REG_DATA_WIDTH = 32,
   parameter int         TIMEOUT        = 1000,
   parameter logic [7:0] CMD_WR         = 8'h57,
   parameter logic [7:0] CMD_RD         = 8'h52
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      rx_ready,
   output logic [REG_ADDR_WIDTH-1:0] addr_out,
   output logic [REG_DATA_WIDTH-1:0] data_out,
   output logic                      write_en,
   input  logic [REG_DATA_WIDTH-1:0] rd_data,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      err_pulse
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RD_WAIT, SEND} state_t;
   state_t state, state_n;
   logic rd_cmd;
   logic [1:0] cnt;
   logic [TW-1:0] tcnt;
   logic [REG_DATA_WIDTH-1:0] sh;
   logic rx_acc, tx_acc, tmo, bad, in_cmd;
   assign rx_acc   = rx_valid & rx_ready;
   assign tx_acc   = tx_valid & tx_ready;
   assign in_cmd   = state == ADDR || state == DATA;
   // An accepted byte on the expiry cycle wins over the timeout.
   assign tmo      = in_cmd && !rx_acc && tcnt == TW'(TIMEOUT - 1);
   assign bad      = state == IDLE && rx_acc && rx_data != CMD_WR && rx_data != CMD_RD;
   assign write_en = state == WRITE;
   assign tx_data  = sh[REG_DATA_WIDTH-1 -: 8];
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = (rx_acc && !bad) ? ADDR : IDLE;
         ADDR:    state_n = rx_acc ? (rd_cmd ? RD_WAIT : DATA) : tmo ? IDLE : ADDR;
         DATA:    state_n = (rx_acc && cnt == 2'd3) ? WRITE : tmo ? IDLE : DATA;
         WRITE:   state_n = IDLE;
         RD_WAIT: state_n = SEND;
         SEND:    state_n = (tx_acc && cnt == 2'd3) ? IDLE : SEND;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rx_ready  <= 1'b0;
         tx_valid  <= 1'b0;
         err_pulse <= 1'b0;
         tcnt      <= '0;
         cnt       <= '0;
         rd_cmd    <= 1'b0;
         addr_out  <= '0;
         data_out  <= '0;
         sh        <= '0;
      end else begin
         state     <= state_n;
         // Handshake flags are decoded from the next state so they are plain flops.
         rx_ready  <= state_n == IDLE || state_n == ADDR || state_n == DATA;
         tx_valid  <= state_n == SEND;
         err_pulse <= bad | tmo;
         tcnt      <= (in_cmd && !rx_acc) ? tcnt + 1'b1 : '0;
         cnt       <= (state == ADDR || state == RD_WAIT) ? 2'd0 :
                      cnt + 2'((state == DATA && rx_acc) || tx_acc);
         if (state == IDLE && rx_acc) rd_cmd <= rx_data == CMD_RD;
         if (state == ADDR && rx_acc) addr_out <= REG_ADDR_WIDTH'(rx_data);
         if (state == DATA && rx_acc) data_out <= {data_out[REG_DATA_WIDTH-9:0], rx_data};
         if (state == RD_WAIT) sh <= rd_data;
         else if (tx_acc) sh <= sh << 8;
      end
   end
endmodule
